// File: rtl/accumulator_bank.sv
// accumulator_bank: 128 x 32-lane x 32-bit accumulator store
// with a 2-stage write pipeline, drain reads and a zero sweep.
module accumulator_bank (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          write_accumulator_i,
  input  logic          accumulator_add_i,
  input  logic [6:0]    accumulator_addr_wr_i,
  input  logic [31:0]   accum_addr_mask_i,
  input  logic [1023:0] mac_result_i,
  input  logic          clear_i,
  input  logic          rd_en_i,
  input  logic [6:0]    rd_addr_i,
  output logic [1023:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          ready_o,
  output logic          busy_o,
  output logic          cmd_err_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic          vld;
    logic          add;
    logic [6:0]    addr;
    logic [31:0]   mask;
    logic [1023:0] data;
  } wr_t;

  typedef struct packed {
    logic          vld;
    logic [6:0]    addr;
    logic [1023:0] data;
  } cm_t;

  state_t        state;
  logic [6:0]    sweep;
  wr_t           s1;
  cm_t           s2;
  logic [1023:0] mem [128];
  logic [1023:0] base;
  logic [1023:0] merged;
  logic [1023:0] rd_row;
  logic          wr_acc;
  logic          rd_acc;

  assign wr_acc = write_accumulator_i & ready_o;
  assign rd_acc = rd_en_i & ready_o;
  assign busy_o = s1.vld | s2.vld | (state == CLEAR);

  // s2 commits on the same edge s1 merges, so forward its row
  always_comb begin
    base = mem[s1.addr];
    if (s2.vld && s2.addr == s1.addr)
      base = s2.data;
    merged = base;
    for (int k = 0; k < 32; k++) begin
      if (s1.mask[k])
        merged[32*k +: 32] = s1.add
          ? base[32*k +: 32] + s1.data[32*k +: 32]
          : s1.data[32*k +: 32];
    end
  end

  always_comb begin
    rd_row = mem[rd_addr_i];
    if (s2.vld && s2.addr == rd_addr_i)
      rd_row = s2.data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      sweep      <= '0;
      s1         <= '0;
      s2         <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      ready_o    <= 1'b1;
      cmd_err_o  <= 1'b0;
    end else begin
      s1 <= '{vld:  wr_acc,
              add:  accumulator_add_i,
              addr: accumulator_addr_wr_i,
              mask: accum_addr_mask_i,
              data: mac_result_i};
      s2 <= '{vld:  s1.vld,
              addr: s1.addr,
              data: merged};
      rd_valid_o <= rd_acc;
      if (rd_acc)
        rd_data_o <= rd_row;
      if ((write_accumulator_i | rd_en_i) & ~ready_o)
        cmd_err_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (clear_i) begin
            state   <= CLEAR;
            sweep   <= '0;
            ready_o <= 1'b0;
          end
        end
        CLEAR: begin
          sweep <= sweep + 7'd1;
          if (sweep == 7'd127) begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // storage has no reset; the sweep wins over a same-edge commit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (s2.vld)
        mem[s2.addr] <= s2.data;
      if (state == CLEAR)
        mem[sweep] <= '0;
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: directed and random stimulus checked
// against a sequential per-lane model of the bank.
module tb_accumulator_bank;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          write_accumulator_i;
  logic          accumulator_add_i;
  logic [6:0]    accumulator_addr_wr_i;
  logic [31:0]   accum_addr_mask_i;
  logic [1023:0] mac_result_i;
  logic          clear_i;
  logic          rd_en_i;
  logic [6:0]    rd_addr_i;
  logic [1023:0] rd_data_o;
  logic          rd_valid_o;
  logic          ready_o;
  logic          busy_o;
  logic          cmd_err_o;

  always #5 clk_i = ~clk_i;

  accumulator_bank dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .write_accumulator_i   (write_accumulator_i),
    .accumulator_add_i     (accumulator_add_i),
    .accumulator_addr_wr_i (accumulator_addr_wr_i),
    .accum_addr_mask_i     (accum_addr_mask_i),
    .mac_result_i          (mac_result_i),
    .clear_i               (clear_i),
    .rd_en_i               (rd_en_i),
    .rd_addr_i             (rd_addr_i),
    .rd_data_o             (rd_data_o),
    .rd_valid_o            (rd_valid_o),
    .ready_o               (ready_o),
    .busy_o                (busy_o),
    .cmd_err_o             (cmd_err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int            due;
    logic [6:0]    addr;
    logic          add;
    logic [31:0]   mask;
    logic [1023:0] data;
  } pend_t;

  logic [31:0]   mm [128][32];
  pend_t         pq [$];
  int            cyc_n = 0;
  logic          m_clearing = 1'b0;
  int            m_idx = 0;
  logic          m_err = 1'b0;
  logic          exp_rv = 1'b0;
  logic [1023:0] exp_rd = '0;
  logic          model_on = 1'b0;

  task automatic check(input string nm,
                       input logic [1023:0] act,
                       input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] row(input int a);
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[32*k +: 32] = mm[a][k];
    return r;
  endfunction

  function automatic logic [1023:0] fill(input logic [31:0] v);
    return {32{v}};
  endfunction

  // Commands apply in acceptance order, two edges after acceptance
  task automatic model_edge();
    pend_t p;
    logic  rdy;
    cyc_n++;
    if (!rst_i) begin
      m_clearing = 1'b0;
      m_idx      = 0;
      pq.delete();
      exp_rv     = 1'b0;
      exp_rd     = '0;
      m_err      = 1'b0;
      return;
    end
    rdy = !m_clearing;
    while (pq.size() > 0 && pq[0].due == cyc_n) begin
      p = pq.pop_front();
      for (int k = 0; k < 32; k++)
        if (p.mask[k])
          mm[p.addr][k] = p.add ? mm[p.addr][k] + p.data[32*k +: 32]
                                : p.data[32*k +: 32];
    end
    if (m_clearing) begin
      for (int k = 0; k < 32; k++) mm[m_idx][k] = '0;
      if (m_idx == 127) m_clearing = 1'b0;
      m_idx = (m_idx + 1) % 128;
    end
    if (rdy) begin
      if (write_accumulator_i) begin
        p.due  = cyc_n + 2;
        p.addr = accumulator_addr_wr_i;
        p.add  = accumulator_add_i;
        p.mask = accum_addr_mask_i;
        p.data = mac_result_i;
        pq.push_back(p);
      end
      exp_rv = rd_en_i;
      if (rd_en_i) exp_rd = row(rd_addr_i);
      if (clear_i) begin
        m_clearing = 1'b1;
        m_idx      = 0;
      end
    end else begin
      exp_rv = 1'b0;
      if (write_accumulator_i || rd_en_i) m_err = 1'b1;
    end
  endtask

  always @(negedge clk_i) begin
    if (model_on) begin
      check("ready", 1024'(ready_o), 1024'(!m_clearing));
      check("busy", 1024'(busy_o), 1024'(m_clearing || pq.size() > 0));
      check("cmd_err", 1024'(cmd_err_o), 1024'(m_err));
      check("rd_valid", 1024'(rd_valid_o), 1024'(exp_rv));
      if (exp_rv) check("rd_data", rd_data_o, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle_in();
    rst_i               = 1'b1;
    write_accumulator_i = 1'b0;
    rd_en_i             = 1'b0;
    clear_i             = 1'b0;
  endtask

  task automatic set_wr(input logic [6:0] a, input logic add,
                        input logic [31:0] m, input logic [1023:0] d);
    write_accumulator_i   = 1'b1;
    accumulator_addr_wr_i = a;
    accumulator_add_i     = add;
    accum_addr_mask_i     = m;
    mac_result_i          = d;
  endtask

  task automatic set_rd(input logic [6:0] a);
    rd_en_i   = 1'b1;
    rd_addr_i = a;
  endtask

  task automatic rd_lit(input logic [6:0] a, input logic [1023:0] exp,
                        input string nm);
    idle_in();
    set_rd(a);
    tick();
    idle_in();
    check({nm, "_valid"}, 1024'(rd_valid_o), 1024'(1));
    check(nm, rd_data_o, exp);
  endtask

  initial begin
    logic [1023:0] d;
    logic [1023:0] e;
    logic [31:0]   m;
    int            sel;

    rst_i                 = 1'b0;
    write_accumulator_i   = 1'b0;
    accumulator_add_i     = 1'b0;
    accumulator_addr_wr_i = '0;
    accum_addr_mask_i     = '0;
    mac_result_i          = '0;
    clear_i               = 1'b0;
    rd_en_i               = 1'b0;
    rd_addr_i             = '0;

    @(negedge clk_i);
    @(posedge clk_i);
    model_edge();
    #1 model_on = 1'b1;
    @(negedge clk_i);
    check("rst_rd_data", rd_data_o, '0);
    check("rst_ready", 1024'(ready_o), 1024'(1));
    check("rst_busy", 1024'(busy_o), 1024'(0));
    check("rst_err", 1024'(cmd_err_o), 1024'(0));

    idle_in();
    clear_i = 1'b1;
    tick();
    idle_in();
    check("clr_ready_low", 1024'(ready_o), 1024'(0));
    repeat (128) tick();
    check("clr_ready_back", 1024'(ready_o), 1024'(1));
    rd_lit(7'd0, '0, "clr_rd0");
    rd_lit(7'd64, '0, "clr_rd64");
    rd_lit(7'd127, '0, "clr_rd127");

    set_wr(7'd5, 1'b0, 32'hFFFF_FFFF, fill(32'd10));
    tick();
    check("no_stall", 1024'(ready_o), 1024'(1));
    set_wr(7'd5, 1'b1, 32'hFFFF_FFFF, fill(32'd3));
    tick();
    idle_in();
    repeat (2) tick();
    rd_lit(7'd5, fill(32'd13), "ovr_add");

    d = '0;
    for (int k = 0; k < 32; k++) d[32*k +: 32] = 32'hDEAD_0000 + 32'(k);
    d[1023:992] = 32'd7;
    set_wr(7'd9, 1'b1, 32'h8000_0000, d);
    tick();
    idle_in();
    repeat (2) tick();
    e = '0;
    e[1023:992] = 32'd7;
    rd_lit(7'd9, e, "mask31");

    set_wr(7'd1, 1'b0, 32'h1, fill(32'h7FFF_FFFF));
    tick();
    set_wr(7'd1, 1'b1, 32'h1, fill(32'h1));
    tick();
    idle_in();
    repeat (2) tick();
    e = '0;
    e[31:0] = 32'h8000_0000;
    rd_lit(7'd1, e, "wrap");
    check("wrap_no_err", 1024'(cmd_err_o), 1024'(0));

    repeat (3) begin
      set_wr(7'd4, 1'b1, 32'hFFFF_FFFF, fill(32'd1));
      tick();
    end
    idle_in();
    repeat (2) tick();
    rd_lit(7'd4, fill(32'd3), "gap_hazard");

    set_wr(7'd6, 1'b1, 32'hFFFF_FFFF, fill(32'd1));
    tick();
    idle_in();
    tick();
    set_wr(7'd6, 1'b1, 32'h0000_FFFF, fill(32'd5));
    tick();
    idle_in();
    repeat (2) tick();
    rd_lit(7'd6, {{16{32'd1}}, {16{32'd6}}}, "gap2_mask");

    set_wr(7'd2, 1'b0, 32'hFFFF_FFFF, fill(32'h55));
    tick();
    idle_in();
    repeat (2) tick();
    clear_i = 1'b1;
    tick();
    idle_in();
    repeat (10) tick();
    clear_i = 1'b1;
    set_wr(7'd3, 1'b0, 32'hFFFF_FFFF, fill(32'h99));
    tick();
    idle_in();
    check("err_set", 1024'(cmd_err_o), 1024'(1));
    repeat (130) tick();
    rd_lit(7'd3, '0, "dropped_wr");
    set_wr(7'd2, 1'b0, 32'hFFFF_FFFF, fill(32'h55));
    tick();
    idle_in();
    repeat (2) tick();
    set_wr(7'd2, 1'b1, 32'hFFFF_FFFF, fill(32'h1));
    tick();
    idle_in();
    rst_i = 1'b0;
    tick();
    idle_in();
    check("rst_err_clr", 1024'(cmd_err_o), 1024'(0));
    check("rst_busy_clr", 1024'(busy_o), 1024'(0));
    repeat (3) tick();
    rd_lit(7'd2, fill(32'h55), "rst_discard");

    for (int i = 0; i < 3000; i++) begin
      idle_in();
      if ($urandom_range(0, 149) == 0) rst_i = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 32; k++)
          d[32*k +: 32] = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF
                                                       : $urandom;
        sel = $urandom_range(0, 3);
        m = (sel == 0) ? 32'hFFFF_FFFF :
            (sel == 1) ? $urandom :
            (sel == 2) ? (32'(1) << $urandom_range(0, 31)) : 32'h0;
        set_wr(7'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, m, d);
      end
      if ($urandom_range(0, 2) == 0) set_rd(7'($urandom_range(0, 7)));
      if (!write_accumulator_i && pq.size() == 0 &&
          $urandom_range(0, 299) == 0)
        clear_i = 1'b1;
      tick();
    end
    idle_in();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_bank.md
ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

Interface
REQ-001 One clock; reset is synchronous and active-low. Ports are clk_i and rst_i.
REQ-002 clk_i  in  1  rising-edge clock for all state.
REQ-003 rst_i  in  1  synchronous active-low reset, sampled on clk_i.
REQ-004 write_accumulator_i  in  1  write command valid this cycle.
REQ-005 accumulator_add_i  in  1  1 = add to stored value; 0 = overwrite.
REQ-006 accumulator_addr_wr_i  in  7  target entry, 0..127.
REQ-007 accum_addr_mask_i  in  32  per-lane write enable; bit k gates lane k.
REQ-008 mac_result_i  in  1024  lane k = bits [32k+31:32k], two's-complement partial sum.
REQ-009 clear_i  in  1  one-cycle pulse; starts a zero sweep of all entries.
REQ-010 rd_en_i  in  1  drain read request.
REQ-011 rd_addr_i  in  7  drain read entry.
REQ-012 rd_data_o  out  1024  drain read data, same lane packing as mac_result_i.
REQ-013 rd_valid_o  out  1  rd_data_o is valid this cycle.
REQ-014 ready_o  out  1  1 when write and read commands are accepted.
REQ-015 busy_o  out  1  1 while any write is in flight or a clear is running.
REQ-016 cmd_err_o  out  1  sticky; set when a command arrives while ready_o=0.

Function
REQ-017 Storage: 128 entries x 32 lanes x 32 bits.
REQ-018 FSM states are IDLE and CLEAR. The FSM moves IDLE->CLEAR on clear_i=1, and CLEAR->IDLE after entry 127 is zeroed.
REQ-019 CLEAR: a 7-bit sweep counter starts at 0 and zeroes one entry per cycle (128 cycles total). ready_o=0 and busy_o=1 throughout.
REQ-020 clear_i received during CLEAR is ignored; the sweep is not restarted.
REQ-021 Write pipeline: a command accepted at edge T commits to storage at edge T+2. busy_o=1 from T+1 until the commit completes.
REQ-022 Commit, per lane k with mask bit k=1:
- add=1: new = stored + mac lane k, modulo 2^32, wrap with no saturation.
- add=0: new = mac lane k.
REQ-023 Lanes with mask bit k=0 keep their stored value bit-exact.
REQ-024 Write command with mask=0 has no effect on storage, but still occupies the pipeline.
REQ-025 Hazards: back-to-back commands to the same address (gap 1 or 2 cycles) produce results identical to strictly sequential execution, per lane and honoring each command's mask. Bypass forwarding provides this with no stall; ready_o stays 1.
REQ-026 Drain read: rd_en_i accepted at edge T gives rd_data_o and rd_valid_o=1 in cycle T+1. rd_valid_o=0 otherwise.
REQ-027 Read data reflects every write committed at or before edge T. Writes still in flight at T are not visible.
REQ-028 Read and write may be accepted in the same cycle to any addresses.
REQ-029 A command (write or read) arriving while ready_o=0 is dropped, and cmd_err_o is set to 1.
REQ-030 cmd_err_o clears only on reset.
REQ-031 All address arithmetic is 7-bit, and the sweep counter wraps 127->0 on exit.

Reset
REQ-032 On rst_i=0 at a clock edge:
- FSM returns to IDLE.
- Sweep counter is 0.
- In-flight writes are discarded and never commit.
- rd_valid_o=0, rd_data_o=0, ready_o=1, busy_o=0, cmd_err_o=0.
REQ-033 Storage contents are not altered by reset. A clear_i pulse is required before contents are defined.
REQ-034 Reset asserted during CLEAR aborts the sweep. Entries already zeroed stay zero; the rest are unchanged.

Verification
REQ-035 Clear then read: pulse clear_i, wait 128 cycles. Response: ready_o returns to 1; read of entries 0, 64 and 127 gives rd_data_o=0 one cycle after rd_en_i.
REQ-036 Overwrite then add: write addr 5, add=0, mask=FFFFFFFF, every lane 10; then addr 5, add=1, mask=FFFFFFFF, every lane 3, on the next cycle. Response: read of addr 5 gives every lane 13, with no stall.
REQ-037 Mask: write addr 9, add=1, mask=80000000, lane 31=7, onto zeroed storage. Response: lane 31=7 and lanes 0..30=0.
REQ-038 Wrap: addr 1 lane 0 holds 7FFFFFFF; add 1. Response: lane 0=80000000, with no flag raised.
REQ-039 Error and reset: write during CLEAR. Response: the write is dropped and cmd_err_o=1. Then apply rst_i=0 for one cycle with a write in flight to addr 2. Response: cmd_err_o=0, busy_o=0, and addr 2 is unchanged.
REQ-040 Gap-2 hazard: add 1 to addr 4 at cycles T, T+1 and T+2, all lanes, from 0. Response: read of addr 4 gives every lane 3.
